seg7_scan: RTL

Four-digit multiplexed seven-segment scan driver sitting directly downstream of the GPIO block. It consumes the 16-bit GPIO display word (`DOUT_7S`) as four hex nibbles and drives the board's common-anode display pins. Digits are time-multiplexed with a programmable slot length and an anti-ghosting blank gap. The word is snapshotted once per frame so a digit never tears mid-scan.

---
 rtl/seg7_scan_if.sv | 21 ++
 rtl/seg7_scan.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_if.sv
// Display-word bus between the GPIO block and the seven-segment scan driver.
`timescale 1ns/1ps
interface seg7_scan_if;
  logic        EN;
  logic [15:0] DIN;
  logic [3:0]  DP_IN;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        FRAME_STB;

  modport master (
    output EN, DIN, DP_IN,
    input  AN, SEG, DP, FRAME_STB
  );

  modport slave (
    input  EN, DIN, DP_IN,
    output AN, SEG, DP, FRAME_STB
  );
endinterface

// File: rtl/seg7_scan.sv
// Four-digit multiplexed common-anode seven-segment scan driver with per-frame snapshot.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
`timescale 1ns/1ps
module seg7_scan #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned GAP      = 1000
) (
  input logic        CLK,
  input logic        RST_n,
  seg7_scan_if.slave bus
);

  localparam int unsigned CntW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(GAP - 1);

  typedef enum logic [0:0] {StGap, StOn} phase_e;

  phase_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [3:0]      dpsh_q, dpsh_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            stb_q, stb_d;

  logic [3:0]      nib;
  logic [3:0]      an_sel;
  logic [6:0]      hex;
  logic            blank_lz;

  // Nibble and anode pattern for the digit currently being scanned.
  always_comb begin
    nib    = 4'h0;
    an_sel = 4'hF;
    unique case (idx_q)
      2'd0: begin nib = shadow_q[3:0];   an_sel = 4'b1110; end
      2'd1: begin nib = shadow_q[7:4];   an_sel = 4'b1101; end
      2'd2: begin nib = shadow_q[11:8];  an_sel = 4'b1011; end
      2'd3: begin nib = shadow_q[15:12]; an_sel = 4'b0111; end
    endcase
  end

  // Active-low gfedcba hex font.
  always_comb begin
    hex = 7'h7F;
    unique case (nib)
      4'h0: hex = 7'b1000000;
      4'h1: hex = 7'b1111001;
      4'h2: hex = 7'b0100100;
      4'h3: hex = 7'b0110000;
      4'h4: hex = 7'b0011001;
      4'h5: hex = 7'b0010010;
      4'h6: hex = 7'b0000010;
      4'h7: hex = 7'b1111000;
      4'h8: hex = 7'b0000000;
      4'h9: hex = 7'b0010000;
      4'hA: hex = 7'b0001000;
      4'hB: hex = 7'b0000011;
      4'hC: hex = 7'b1000110;
      4'hD: hex = 7'b0100001;
      4'hE: hex = 7'b0000110;
      4'hF: hex = 7'b0001110;
    endcase
  end

`ifdef SEG7_LZ_BLANK_EN
  // lz[i]: nibbles i..3 of the snapshot are all zero; digit 0 is never blanked.
  logic [3:0] lz;
  always_comb begin
    lz[3] = (shadow_q[15:12] == 4'h0);
    lz[2] = lz[3] && (shadow_q[11:8] == 4'h0);
    lz[1] = lz[2] && (shadow_q[7:4] == 4'h0);
    lz[0] = 1'b0;
  end
  assign blank_lz = lz[idx_q];
`else
  assign blank_lz = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    dpsh_d   = dpsh_q;
    an_d     = 4'hF;
    seg_d    = 7'h7F;
    dp_d     = 1'b1;
    stb_d    = 1'b0;

    if (!bus.EN) begin
      state_d = StGap;
      cnt_d   = '0;
      idx_d   = 2'd0;
    end else begin
      if (cnt_q == '0 && idx_q == 2'd0) begin
        shadow_d = bus.DIN;
        dpsh_d   = bus.DP_IN;
        stb_d    = 1'b1;
      end

      if (cnt_q == CntLast) begin
        state_d = StGap;
        cnt_d   = '0;
        idx_d   = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == GapLast) state_d = StOn;
      end

      unique case (state_q)
        StGap: ;
        StOn: begin
          dp_d = ~dpsh_q[idx_q];
          if (!blank_lz) begin
            an_d  = an_sel;
            seg_d = hex;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= StGap;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      dpsh_q   <= 4'h0;
      an_q     <= 4'hF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      stb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      dpsh_q   <= dpsh_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      stb_q    <= stb_d;
    end
  end

  assign bus.AN        = an_q;
  assign bus.SEG       = seg_q;
  assign bus.DP        = dp_q;
  assign bus.FRAME_STB = stb_q;

endmodule
